// File: rtl/add_bist.sv
`default_nettype none
// ============================================================================
// Module   : add_bist
// Brief    : LFSR-driven self-test for a 32-bit adder with a LAT-deep checker
//            pipeline. Define ADD_BIST_SIGNATURE_EN to add the 33-bit sig MISR.
// Revision : 1.0
// ============================================================================
module add_bist #(
    parameter int          N_VEC  = 16,
    parameter int          LAT    = 1,
    parameter logic [31:0] SEED_A = 32'h00000001,
    parameter logic [31:0] SEED_B = 32'h00000002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] A,
    output logic [31:0] B,
    input  logic [32:0] Sum,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_idx
`ifdef ADD_BIST_SIGNATURE_EN
    ,
    output logic [32:0] sig
`endif
);

    localparam logic [31:0] C_POLY       = 32'h80200003;
    localparam logic [31:0] C_SEED_A     = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
    localparam logic [31:0] C_SEED_B     = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
    localparam logic [15:0] C_LAST       = 16'(N_VEC - 1);
    // Unreachable when LAT=0 because RUN then goes straight to DONE.
    localparam logic [2:0]  C_DRAIN_LAST = 3'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_lfsr_a;
    logic [31:0] r_lfsr_b;
    logic [15:0] r_vec_idx;
    logic [2:0]  r_drain_cnt;

    logic        w_vld_now;
    logic [32:0] w_exp_now;
    logic        w_cmp_vld;
    logic [32:0] w_cmp_exp;
    logic [15:0] w_cmp_idx;
    logic        w_mismatch;
    logic [15:0] w_err_nxt;
    logic        w_enter_run;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? C_POLY : 32'h0);
    endfunction

    assign w_vld_now   = (r_state == S_RUN);
    assign w_exp_now   = {A[31], A} + {B[31], B};
    assign w_enter_run = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

    generate
        if (LAT == 0) begin : g_lat0
            assign w_cmp_vld = w_vld_now;
            assign w_cmp_exp = w_exp_now;
            assign w_cmp_idx = r_vec_idx;
        end else begin : g_pipe
            logic [32:0]    r_exp [LAT];
            logic [15:0]    r_idx [LAT];
            logic [LAT-1:0] r_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_vld_now;
                    for (int i = 1; i < LAT; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
                r_exp[0] <= w_exp_now;
                r_idx[0] <= r_vec_idx;
                for (int i = 1; i < LAT; i++) begin
                    r_exp[i] <= r_exp[i-1];
                    r_idx[i] <= r_idx[i-1];
                end
            end

            assign w_cmp_vld = r_vld[LAT-1];
            assign w_cmp_exp = r_exp[LAT-1];
            assign w_cmp_idx = r_idx[LAT-1];
        end
    endgenerate

    always_comb begin
        w_mismatch = w_cmp_vld && (Sum != w_cmp_exp);
        w_err_nxt  = err_cnt;
        if (w_mismatch && (err_cnt != 16'hFFFF)) begin
            w_err_nxt = err_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            A             <= 32'h0;
            B             <= 32'h0;
            r_lfsr_a      <= C_SEED_A;
            r_lfsr_b      <= C_SEED_B;
            r_vec_idx     <= 16'h0;
            r_drain_cnt   <= 3'h0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= 16'h0;
            first_err_idx <= 16'hFFFF;
        end else begin
            err_cnt <= w_err_nxt;
            if (w_mismatch && (err_cnt == 16'h0)) begin
                first_err_idx <= w_cmp_idx;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // The checker is idle here, so these clears never lose a compare.
                        r_state       <= S_RUN;
                        r_lfsr_a      <= C_SEED_A;
                        r_lfsr_b      <= C_SEED_B;
                        A             <= C_SEED_A;
                        B             <= C_SEED_B;
                        r_vec_idx     <= 16'h0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_cnt       <= 16'h0;
                        first_err_idx <= 16'hFFFF;
                    end
                end
                S_RUN: begin
                    if (r_vec_idx == C_LAST) begin
                        A <= 32'h0;
                        B <= 32'h0;
                        if (LAT == 0) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_err_nxt == 16'h0);
                        end else begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= 3'h0;
                        end
                    end else begin
                        r_lfsr_a  <= lfsr_step(r_lfsr_a);
                        r_lfsr_b  <= lfsr_step(r_lfsr_b);
                        A         <= lfsr_step(r_lfsr_a);
                        B         <= lfsr_step(r_lfsr_b);
                        r_vec_idx <= r_vec_idx + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == C_DRAIN_LAST) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_nxt == 16'h0);
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ADD_BIST_SIGNATURE_EN
    always_ff @(posedge clk) begin
        if (rst || w_enter_run) begin
            sig <= 33'h0;
        end else if (w_cmp_vld) begin
            sig <= {sig[31:0], sig[32]} ^ Sum;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_bist.sv
`default_nettype none
// Bench for add_bist: three instances (LAT=1/N=16, LAT=0/N=4, LAT=4/N=16) checked every
// cycle against a timeline model built from start/rst history and precomputed vectors.
module tb_add_bist;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;

    int          mode  = 0;
    logic [3:0]  key4  = 4'h0;
    int          fb    = 0;
    logic [31:0] key32 = 32'h0;

    logic [31:0] a_0, a_1, a_2, b_0, b_1, b_2;
    logic [32:0] s_0, s_1, s_2;
    logic        busy_0, busy_1, busy_2, done_0, done_1, done_2, pass_0, pass_1, pass_2;
    logic [15:0] err_0, err_1, err_2, fidx_0, fidx_1, fidx_2;
`ifdef ADD_BIST_SIGNATURE_EN
    logic [32:0] sig_0, sig_1, sig_2;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int nv(input int k);
        return (k == 1) ? 4 : 16;
    endfunction

    function automatic int lt(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 4);
    endfunction

    function automatic logic [32:0] exact(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        return s[32:0];
    endfunction

    function automatic logic [32:0] faulty(input int m, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = exact(a, b);
        if (m == 1) r[0] = 1'b0;
        else if (m == 2 && a[3:0] == key4) r[fb] = ~r[fb];
        else if (m == 3 && a == key32) r[fb] = ~r[fb];
        return r;
    endfunction

    add_bist #(.N_VEC(16), .LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .A(a_0), .B(b_0), .Sum(s_0),
        .busy(busy_0), .done(done_0), .pass(pass_0), .err_cnt(err_0), .first_err_idx(fidx_0)
`ifdef ADD_BIST_SIGNATURE_EN
        , .sig(sig_0)
`endif
    );
    add_bist #(.N_VEC(4), .LAT(0)) u_l0 (
        .clk(clk), .rst(rst), .start(start), .A(a_1), .B(b_1), .Sum(s_1),
        .busy(busy_1), .done(done_1), .pass(pass_1), .err_cnt(err_1), .first_err_idx(fidx_1)
`ifdef ADD_BIST_SIGNATURE_EN
        , .sig(sig_1)
`endif
    );
    add_bist #(.N_VEC(16), .LAT(4)) u_l4 (
        .clk(clk), .rst(rst), .start(start), .A(a_2), .B(b_2), .Sum(s_2),
        .busy(busy_2), .done(done_2), .pass(pass_2), .err_cnt(err_2), .first_err_idx(fidx_2)
`ifdef ADD_BIST_SIGNATURE_EN
        , .sig(sig_2)
`endif
    );

    // Adders under test: registered (with injectable faults), combinational, 4-stage.
    logic [32:0] p4 [4];
    always_ff @(posedge clk) begin
        s_0   <= faulty(mode, a_0, b_0);
        p4[0] <= exact(a_2, b_2);
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
    assign s_1 = exact(a_1, b_1);
    assign s_2 = p4[3];

    logic [31:0] a_v [NI], b_v [NI];
    logic        busy_v [NI], done_v [NI], pass_v [NI];
    logic [15:0] err_v [NI], fidx_v [NI];
    logic [32:0] sig_v [NI];
    always_comb begin
        a_v[0] = a_0;  a_v[1] = a_1;  a_v[2] = a_2;
        b_v[0] = b_0;  b_v[1] = b_1;  b_v[2] = b_2;
        busy_v[0] = busy_0; busy_v[1] = busy_1; busy_v[2] = busy_2;
        done_v[0] = done_0; done_v[1] = done_1; done_v[2] = done_2;
        pass_v[0] = pass_0; pass_v[1] = pass_1; pass_v[2] = pass_2;
        err_v[0]  = err_0;  err_v[1]  = err_1;  err_v[2]  = err_2;
        fidx_v[0] = fidx_0; fidx_v[1] = fidx_1; fidx_v[2] = fidx_2;
`ifdef ADD_BIST_SIGNATURE_EN
        sig_v[0] = sig_0; sig_v[1] = sig_1; sig_v[2] = sig_2;
`else
        sig_v[0] = 33'h0; sig_v[1] = 33'h0; sig_v[2] = 33'h0;
`endif
    end

    task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL inst%0d %s: got %0h, expected %0h at %0t", k, nm, act, exp, $time);
    endtask

    // Reference model: vectors, per-instance timeline and end-of-run predictions.
    logic [31:0] va [16], vb [16];
    bit          acc [NI];
    int          ph [NI];
    int          exp_err [NI], exp_fidx [NI];
    logic [32:0] exp_sig [NI], clean_sig [NI];

    task automatic predict(input int k);
        int m, e, f;
        logic [32:0] s, cs, su, ex;
        m = (k == 0) ? mode : 0;
        e = 0; f = 16'hFFFF; s = '0; cs = '0;
        for (int i = 0; i < nv(k); i++) begin
            ex = exact(va[i], vb[i]);
            su = faulty(m, va[i], vb[i]);
            if (su != ex) begin
                if (e == 0) f = i;
                if (e < 65535) e++;
            end
            s  = {s[31:0], s[32]} ^ su;
            cs = {cs[31:0], cs[32]} ^ ex;
        end
        exp_err[k] = e; exp_fidx[k] = f; exp_sig[k] = s; clean_sig[k] = cs;
    endtask

    initial begin
        va[0] = 32'h1; vb[0] = 32'h2;
        for (int i = 1; i < 16; i++) begin
            va[i] = (va[i-1] >> 1) ^ (va[i-1][0] ? 32'h80200003 : 32'h0);
            vb[i] = (vb[i-1] >> 1) ^ (vb[i-1][0] ? 32'h80200003 : 32'h0);
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) begin
                if (rst) begin
                    acc[k] = 1'b0; ph[k] = 0;
                end else if (start && (!acc[k] || ph[k] >= nv(k) + lt(k))) begin
                    acc[k] = 1'b1; ph[k] = 0; predict(k);
                end else if (acc[k]) begin
                    ph[k] = ph[k] + 1;
                end
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                logic [31:0] ea, eb;
                logic eb_busy, eb_done;
                ea = 32'h0; eb = 32'h0;
                if (acc[k] && ph[k] < nv(k)) begin
                    ea = va[ph[k]]; eb = vb[ph[k]];
                end
                eb_busy = acc[k] && (ph[k] < nv(k) + lt(k));
                eb_done = acc[k] && (ph[k] >= nv(k) + lt(k));
                chk(k, "busy", busy_v[k], eb_busy);
                chk(k, "done", done_v[k], eb_done);
                chk(k, "A", a_v[k], ea);
                chk(k, "B", b_v[k], eb);
                if (!acc[k]) begin
                    chk(k, "idle_err_cnt", err_v[k], 0);
                    chk(k, "idle_first_err_idx", fidx_v[k], 16'hFFFF);
                    chk(k, "idle_pass", pass_v[k], 0);
                    chk(k, "idle_sig", sig_v[k], 0);
                end else if (eb_done) begin
                    chk(k, "err_cnt", err_v[k], exp_err[k]);
                    chk(k, "first_err_idx", fidx_v[k], exp_fidx[k]);
                    chk(k, "pass", pass_v[k], exp_err[k] == 0);
`ifdef ADD_BIST_SIGNATURE_EN
                    chk(k, "sig", sig_v[k], exp_sig[k]);
`endif
                end else begin
                    chk(k, "busy_pass", pass_v[k], 0);
                    if (ph[k] == 0) begin
                        chk(k, "entry_err_cnt", err_v[k], 0);
                        chk(k, "entry_first_err_idx", fidx_v[k], 16'hFFFF);
                        chk(k, "entry_sig", sig_v[k], 0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done_0 !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        chk(0, "done_timeout", done_0, 1);
    endtask

    initial begin
        int t_done [NI];
        rst = 1'b1; start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Clean run: timing and first vectors pinned by hand.
        for (int k = 0; k < NI; k++) t_done[k] = 0;
        pulse_start();
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            if (j == 1) begin
                chk(0, "lit_A0", a_0, 32'h1);
                chk(0, "lit_B0", b_0, 32'h2);
            end
            if (j == 2) begin
                chk(0, "lit_A1", a_0, 32'h80200003);
                chk(0, "lit_B1", b_0, 32'h1);
            end
            if (j == 3) chk(0, "lit_A2", a_0, 32'hC0300002);
            for (int k = 0; k < NI; k++)
                if (done_v[k] === 1'b1 && t_done[k] == 0) t_done[k] = j;
        end
        chk(0, "lit_done_lat1", t_done[0], 18);
        chk(1, "lit_done_lat0", t_done[1], 5);
        chk(2, "lit_done_lat4", t_done[2], 21);
        chk(0, "lit_pass", pass_0, 1);
        chk(0, "lit_err_cnt", err_0, 0);
        chk(0, "lit_first_err_idx", fidx_0, 16'hFFFF);
        chk(1, "lit_pass", pass_1, 1);

        // Sum[0] stuck-at-0: vector 0 (1+2=3) is the first failure.
        tick();
        mode = 1;
        pulse_start();
        wait_done();
        @(negedge clk);
        chk(0, "lit_stuck_first", fidx_0, 0);
        chk(0, "lit_stuck_pass", pass_0, 0);

        // Start held through whole runs; restart from DONE clears err_cnt.
        tick();
        mode = 0;
        start = 1'b1;
        tick();
        @(negedge clk);
        chk(0, "lit_restart_busy", busy_0, 1);
        chk(0, "lit_restart_err", err_0, 0);
        repeat (44) tick();
        start = 1'b0;
        wait_done();

        // Reset during the 8th RUN cycle, then rerun from vector 0.
        tick();
        pulse_start();
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk(0, "lit_rst_busy", busy_0, 0);
        chk(0, "lit_rst_A", a_0, 0);
        chk(0, "lit_rst_B", b_0, 0);
        tick();
        pulse_start();
        @(negedge clk);
        chk(0, "lit_rerun_A", a_0, 32'h1);
        chk(0, "lit_rerun_B", b_0, 32'h2);
        wait_done();

        // Single corrupted Sum on vector 9.
        tick();
        mode = 3; fb = 7; key32 = va[9];
        pulse_start();
        wait_done();
        @(negedge clk);
        chk(0, "lit_single_err", err_0, 1);
        chk(0, "lit_single_first", fidx_0, 9);
`ifdef ADD_BIST_SIGNATURE_EN
        chk(0, "sig_differs", sig_0 != clean_sig[0], 1);
`endif

        // Randomized runs: fault mode, fault keys, idle gaps and start lengths.
        for (int it = 0; it < 12; it++) begin
            tick();
            mode  = int'($urandom_range(0, 3));
            key4  = 4'($urandom_range(0, 15));
            fb    = int'($urandom_range(0, 32));
            key32 = va[$urandom_range(0, 15)];
            repeat ($urandom_range(0, 4)) tick();
            start = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            start = 1'b0;
            wait_done();
        end

        repeat (25) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
